// File: rtl/osg_seq_pkg.sv
// Shared types and defaults for the pulse-train sequencer and its Delay-facing fields.
package osg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_PL_W  = 16;
  localparam int WD_W      = 24;
  localparam logic [WD_W-1:0] DEF_WDOG = 24'd10_000_000;

  // Field widths of the Delay block configuration inputs.
  localparam int DELAY_W = 17;
  localparam int MLT_W   = 5;

endpackage

// File: rtl/osg_down_counter.sv
// Loadable down-counter that holds at zero; zero flag is combinational from the count.
module osg_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_seq.sv
// Generates N light pulses of pl_len clocks separated by launches of the external
// Delay block, with a watchdog on each gap and registered outputs throughout.
module pulse_train_seq
  import osg_seq_pkg::*;
#(
  parameter int              CNT_W = DEF_CNT_W,
  parameter int              PL_W  = DEF_PL_W,
  parameter logic [WD_W-1:0] WDOG  = DEF_WDOG
) (
  input  logic               clk_Seq,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   n_pulses,
  input  logic [PL_W-1:0]    pl_len,
  input  logic [DELAY_W-1:0] delay_in,
  input  logic [MLT_W-1:0]   dl_mlt_in,
  input  logic               dl_done,
  output logic               dl_launch,
  output logic [DELAY_W-1:0] delay_q,
  output logic [MLT_W-1:0]   dl_mlt_q,
  output logic               light_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   pulse_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PL_W-1:0]  PL_ONE  = {{(PL_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  WD_LOAD = WDOG - WD_ONE;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] n_q;
  logic [PL_W-1:0]  pl_q;

  logic             accept;
  logic             err_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] idx_nxt;

  logic             pw_load, pw_en, pw_zero;
  logic [PL_W-1:0]  pw_val;
  logic             wd_load, wd_en, wd_zero;

  // Counters are loaded with length-1 so the zero flag marks the final cycle.
  osg_down_counter #(.W(PL_W)) u_pw_cnt (
    .clk      (clk_Seq),
    .rst_n    (rst_n),
    .load     (pw_load),
    .en       (pw_en),
    .load_val (pw_val),
    .zero     (pw_zero)
  );

  osg_down_counter #(.W(WD_W)) u_wd_cnt (
    .clk      (clk_Seq),
    .rst_n    (rst_n),
    .load     (wd_load),
    .en       (wd_en),
    .load_val (WD_LOAD),
    .zero     (wd_zero)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_nxt   = err;
    done_nxt  = 1'b0;
    idx_nxt   = pulse_idx;
    pw_load   = 1'b0;
    pw_en     = 1'b0;
    pw_val    = pl_q - PL_ONE;
    wd_load   = 1'b0;
    wd_en     = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Zero fields would underflow Delay's delay-1 count, so they are rejected.
            if ((n_pulses != '0) && (pl_len != '0) && (delay_in != '0)) begin
              accept    = 1'b1;
              err_nxt   = 1'b0;
              idx_nxt   = CNT_ONE;
              pw_load   = 1'b1;
              pw_val    = pl_len - PL_ONE;
              state_nxt = ST_PULSE;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        ST_PULSE: begin
          pw_en = 1'b1;
          if (pw_zero) begin
            if (pulse_idx == n_q) begin
              done_nxt  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              wd_load   = 1'b1;
              state_nxt = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          wd_en = 1'b1;
          if (dl_done) begin
            idx_nxt   = pulse_idx + CNT_ONE;
            pw_load   = 1'b1;
            state_nxt = ST_PULSE;
          end else if (wd_zero) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_Seq) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      light_out <= 1'b0;
      dl_launch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      pulse_idx <= '0;
      delay_q   <= '0;
      dl_mlt_q  <= '0;
      n_q       <= '0;
      pl_q      <= '0;
    end else begin
      state     <= state_nxt;
      light_out <= (state_nxt == ST_PULSE);
      dl_launch <= (state_nxt == ST_GAP);
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
      err       <= err_nxt;
      pulse_idx <= idx_nxt;
      if (accept) begin
        n_q      <= n_pulses;
        pl_q     <= pl_len;
        delay_q  <= delay_in;
        dl_mlt_q <= dl_mlt_in;
      end
    end
  end

endmodule
